spi_master_burst: RTL and testbench
===================================

Name: spi_master_burst

Overview:
- Parametrised successor to the single-byte SPI master used for the ADS1292 interface.
- Adds configurable word width and SPI mode (CPOL/CPHA), plus an integrated active-low chip select held across a multi-word burst.
- Adds programmable CS setup, hold and idle timing.
- Sits between the ADS1292 controller FSM and the device pins, so a full status+data read (9 bytes) runs as one CS-framed burst.

Parameters:
- WORD_W, 8: bits per SPI word, MSB first; legal 4..32.
- CPOL, 0: SPI clock idle level.
- CPHA, 0: 0 = sample on leading edge, 1 = sample on trailing edge.
- CLKS_PER_HALF_BIT, 4: i_CLK cycles per SCLK half period; legal >= 2.
- CNT_W, 4: width of the burst word count.
- CS_SETUP_CLKS, 2: i_CLK cycles from CS_n falling to the first SCLK edge; legal >= 1.
- CS_HOLD_CLKS, 2: i_CLK cycles from the last SCLK edge to CS_n rising; legal >= 1.
- CS_IDLE_CLKS, 2: minimum i_CLK cycles CS_n stays high between bursts; legal >= 1.

Ports:
- i_CLK, input, 1: system clock; all logic is rising-edge.
- i_RST, input, 1: asynchronous, active-high reset.
- i_TX_Word, input, WORD_W: word to transmit; sampled when i_TX_DV and o_TX_Ready are both 1.
- i_TX_Count, input, CNT_W: number of words in the burst; sampled only on the first accepted word; 0 is treated as 1.
- i_TX_DV, input, 1: valid strobe for the TX word.
- o_TX_Ready, output, 1: block can accept a word this cycle.
- o_RX_DV, output, 1: one-cycle pulse when a received word is complete.
- o_RX_Word, output, WORD_W: last received word.
- o_RX_Index, output, CNT_W: index of the word in o_RX_Word within the burst, counting from 0.
- o_Busy, output, 1: high from first word acceptance until CS idle time has expired.
- o_SPI_Clk, output, 1: SCLK, registered.
- i_SPI_MISO, input, 1: serial data in.
- o_SPI_MOSI, output, 1: serial data out, registered.
- o_SPI_CS_n, output, 1: chip select, active low, registered.

Behaviour:
- Reset values: o_TX_Ready=1, o_RX_DV=0, o_RX_Word=0, o_RX_Index=0, o_Busy=0, o_SPI_Clk=CPOL, o_SPI_MOSI=0, o_SPI_CS_n=1. The FSM is in IDLE and all counters are 0.
- Asserting i_RST mid-burst aborts immediately and asynchronously: CS_n goes to 1, SCLK to CPOL, no o_RX_DV is generated.
- FSM states: IDLE, CS_SETUP, XFER, WAIT_WORD, CS_HOLD, CS_IDLE.
- IDLE: o_TX_Ready=1. On i_TX_DV:
  - latch the word into the shift register;
  - latch words_left = max(i_TX_Count,1);
  - clear o_RX_Index;
  - next cycle drive CS_n=0 and go to CS_SETUP.
- CS_SETUP: o_TX_Ready=0. Wait CS_SETUP_CLKS cycles, then go to XFER. With CPHA=0, MOSI already shows word bit WORD_W-1 when CS_n falls.
- XFER: generate 2*WORD_W SCLK edges, toggling every CLKS_PER_HALF_BIT cycles. The first edge is the leading edge.
  - CPHA=0: sample MISO on leading edges; update MOSI to the next bit on trailing edges, except after the final trailing edge.
  - CPHA=1: update MOSI on leading edges; sample MISO on trailing edges.
  - After the last edge, SCLK is at CPOL again.
- Word completion:
  - o_RX_Word is updated and o_RX_DV pulses exactly 1 cycle after the i_CLK on which the final sampling edge is registered. o_RX_Index holds this word's index in the same cycle.
  - o_RX_Word stays stable until the next o_RX_DV.
  - o_RX_Index increments after each o_RX_DV pulse.
  - words_left is decremented at completion.
  - If words_left is still > 0: go to WAIT_WORD. Otherwise go to CS_HOLD.
- WAIT_WORD: o_TX_Ready=1, CS_n held low, SCLK held at CPOL.
  - On i_TX_DV: latch the word, set MOSI to its MSB (CPHA=0), and enter XFER on the next cycle.
  - Stalling is unbounded.
  - i_TX_Count is ignored here.
- CS_HOLD: wait CS_HOLD_CLKS cycles, then drive CS_n=1 and go to CS_IDLE.
- CS_IDLE: wait CS_IDLE_CLKS cycles; o_TX_Ready=0 and o_Busy=1 throughout. Then go to IDLE, where o_TX_Ready=1.
- i_TX_DV while o_TX_Ready=0 is ignored, with no side effects.
- The o_TX_Ready=1 cycle and i_TX_DV accept in the same cycle (combinational accept on a registered ready).
- Counter widths:
  - half-bit counter: clog2(CLKS_PER_HALF_BIT) bits, wrapping to 0;
  - edge counter: clog2(2*WORD_W+1) bits;
  - words_left: CNT_W bits, never wraps because the FSM leaves XFER at 0.
- A burst with i_TX_Count = 2^CNT_W-1 must complete without overflow.

Decomposition:
- Package spi_pkg: FSM state enum (spi_state_t), a clog2 function, and parameter legality checks as elaboration-time assertions.
- One sub-module, spi_sclk_gen. It owns the half-bit counter and edge counter. Outputs: sclk, leading_pulse, trailing_pulse, done_pulse. Inputs: start and CPOL.
- spi_master_burst owns the FSM, CS timing counters, shift registers and handshake.

Test Plan:
- Mode 0, WORD_W=8, CLKS_PER_HALF_BIT=4, single word 0xA5, MISO loopback from MOSI:
  - o_RX_DV pulses once with o_RX_Word=0xA5, o_RX_Index=0;
  - 16 SCLK edges;
  - CS_n low for 2+64+2 cycles, then high for at least 2 cycles.
- Mode 3 (CPOL=1, CPHA=1), burst i_TX_Count=9 of 0x20..0x28, MISO fed from an ADS1292 model returning 0xC0,0x00,0x00,0x12..0x17:
  - 9 o_RX_DV pulses with o_RX_Index 0..8 and matching data;
  - CS_n never deasserts mid-burst.
- Stall: in a burst of 3, withhold the second i_TX_DV for 50 cycles:
  - SCLK holds at CPOL, CS_n stays 0, o_TX_Ready=1 throughout;
  - burst resumes correctly.
- i_TX_Count=0 -> single-word transfer; i_TX_DV pulsed during XFER -> ignored, MOSI stream unchanged.
- Assert i_RST for 1 cycle at edge 7 of word 1 of a 4-word burst:
  - CS_n=1, SCLK=CPOL and o_TX_Ready=1 immediately;
  - no o_RX_DV;
  - the next burst behaves normally.
- WORD_W=24, CLKS_PER_HALF_BIT=2, mode 1, send 0x800001:
  - MOSI bit stream 1000...0001;
  - o_RX_Word equals the MISO pattern 0x5A5A5A.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared state type and elaboration helpers for the burst SPI master.
package spi_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCsSetup,
        StXfer,
        StWaitWord,
        StCsHold,
        StCsIdle
    } spi_state_t;

    // Ceiling log2, never narrower than one bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 1;
        while ((64'd1 << r) < 64'(n)) r = r + 1;
        return r;
    endfunction

    function automatic bit params_ok(input int unsigned word_w, input int unsigned cphb,
                                     input int unsigned setup, input int unsigned hold,
                                     input int unsigned idle);
        return (word_w >= 4) && (word_w <= 32) && (cphb >= 2) &&
               (setup >= 1) && (hold >= 1) && (idle >= 1);
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK generator: runs 2*WORD_W half periods after start and flags each edge.
module spi_sclk_gen
    import spi_pkg::*;
#(
    parameter int unsigned WORD_W            = 8,
    parameter int unsigned CLKS_PER_HALF_BIT = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    input  logic cpol_i,
    output logic sclk_o,
    output logic leading_pulse_o,
    output logic trailing_pulse_o,
    output logic done_pulse_o
);

    localparam int unsigned HalfW = clog2(CLKS_PER_HALF_BIT);
    localparam int unsigned EdgeW = clog2(2 * WORD_W + 1);
    localparam logic [HalfW-1:0] HalfLast = HalfW'(CLKS_PER_HALF_BIT - 1);
    localparam logic [EdgeW-1:0] EdgeLast = EdgeW'(2 * WORD_W - 1);

    logic             running_q;
    logic [HalfW-1:0] half_q;
    logic [EdgeW-1:0] edge_q;
    logic             phase_q;
    logic             toggle;

    // Phase is kept relative to idle so reset needs no knowledge of CPOL.
    assign sclk_o           = phase_q ^ cpol_i;
    assign toggle           = running_q && (half_q == HalfLast);
    assign leading_pulse_o  = toggle && !edge_q[0];
    assign trailing_pulse_o = toggle && edge_q[0];
    assign done_pulse_o     = toggle && (edge_q == EdgeLast);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            running_q <= 1'b0;
            half_q    <= '0;
            edge_q    <= '0;
            phase_q   <= 1'b0;
        end else if (start_i) begin
            running_q <= 1'b1;
            half_q    <= '0;
            edge_q    <= '0;
            phase_q   <= 1'b0;
        end else if (running_q) begin
            if (toggle) begin
                half_q  <= '0;
                phase_q <= ~phase_q;
                if (edge_q == EdgeLast) begin
                    running_q <= 1'b0;
                    edge_q    <= '0;
                end else begin
                    edge_q <= edge_q + EdgeW'(1);
                end
            end else begin
                half_q <= half_q + HalfW'(1);
            end
        end
    end

endmodule

// File: rtl/spi_master_burst.sv
// SPI master with configurable word width and mode, moving CS-framed multi-word bursts.
module spi_master_burst
    import spi_pkg::*;
#(
    parameter int unsigned WORD_W            = 8,
    parameter bit          CPOL              = 1'b0,
    parameter bit          CPHA              = 1'b0,
    parameter int unsigned CLKS_PER_HALF_BIT = 4,
    parameter int unsigned CNT_W             = 4,
    parameter int unsigned CS_SETUP_CLKS     = 2,
    parameter int unsigned CS_HOLD_CLKS      = 2,
    parameter int unsigned CS_IDLE_CLKS      = 2
) (
    input  logic              i_CLK,
    input  logic              i_RST,
    input  logic [WORD_W-1:0] i_TX_Word,
    input  logic [CNT_W-1:0]  i_TX_Count,
    input  logic              i_TX_DV,
    output logic              o_TX_Ready,
    output logic              o_RX_DV,
    output logic [WORD_W-1:0] o_RX_Word,
    output logic [CNT_W-1:0]  o_RX_Index,
    output logic              o_Busy,
    output logic              o_SPI_Clk,
    input  logic              i_SPI_MISO,
    output logic              o_SPI_MOSI,
    output logic              o_SPI_CS_n
);

    if (!params_ok(WORD_W, CLKS_PER_HALF_BIT, CS_SETUP_CLKS, CS_HOLD_CLKS,
                   CS_IDLE_CLKS)) begin : g_bad_params
        $error("spi_master_burst: illegal parameter set");
    end

    localparam int unsigned MaxCs   = (CS_SETUP_CLKS > CS_HOLD_CLKS) ?
                                      ((CS_SETUP_CLKS > CS_IDLE_CLKS) ? CS_SETUP_CLKS : CS_IDLE_CLKS) :
                                      ((CS_HOLD_CLKS > CS_IDLE_CLKS) ? CS_HOLD_CLKS : CS_IDLE_CLKS);
    localparam int unsigned CsCntW  = clog2(MaxCs);
    localparam int unsigned BitW    = clog2(WORD_W);
    localparam logic [CsCntW-1:0] SetupLast = CsCntW'(CS_SETUP_CLKS - 1);
    localparam logic [CsCntW-1:0] HoldLast  = CsCntW'(CS_HOLD_CLKS - 1);
    localparam logic [CsCntW-1:0] IdleLast  = CsCntW'(CS_IDLE_CLKS - 1);
    localparam logic [BitW-1:0]   BitLast   = BitW'(WORD_W - 1);

    spi_state_t        state_q;
    logic [CsCntW-1:0] cs_cnt_q;
    logic [CNT_W-1:0]  words_left_q;
    logic [WORD_W-1:0] tx_sr_q;
    logic [WORD_W-2:0] rx_sr_q;
    logic [BitW-1:0]   bit_cnt_q;
    logic              mosi_q;
    logic              cs_n_q;
    logic              tx_ready_q;
    logic              busy_q;
    logic              rx_dv_q;
    logic [WORD_W-1:0] rx_word_q;
    logic [CNT_W-1:0]  rx_index_q;

    logic accept, sclk_start, lead_pulse, trail_pulse, done_pulse, sample_pulse, shift_pulse;

    assign accept       = i_TX_DV && tx_ready_q;
    assign sclk_start   = ((state_q == StCsSetup) && (cs_cnt_q == SetupLast)) ||
                          ((state_q == StWaitWord) && accept);
    assign sample_pulse = CPHA ? trail_pulse : lead_pulse;
    // Mode 0 preloads the MSB, so the final trailing edge has nothing left to shift.
    assign shift_pulse  = CPHA ? lead_pulse : (trail_pulse && !done_pulse);

    spi_sclk_gen #(
        .WORD_W           (WORD_W),
        .CLKS_PER_HALF_BIT(CLKS_PER_HALF_BIT)
    ) u_sclk_gen (
        .clk_i           (i_CLK),
        .rst_i           (i_RST),
        .start_i         (sclk_start),
        .cpol_i          (CPOL),
        .sclk_o          (o_SPI_Clk),
        .leading_pulse_o (lead_pulse),
        .trailing_pulse_o(trail_pulse),
        .done_pulse_o    (done_pulse)
    );

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state_q      <= StIdle;
            cs_cnt_q     <= '0;
            words_left_q <= '0;
            tx_sr_q      <= '0;
            rx_sr_q      <= '0;
            bit_cnt_q    <= '0;
            mosi_q       <= 1'b0;
            cs_n_q       <= 1'b1;
            tx_ready_q   <= 1'b1;
            busy_q       <= 1'b0;
            rx_dv_q      <= 1'b0;
            rx_word_q    <= '0;
            rx_index_q   <= '0;
        end else begin
            rx_dv_q <= 1'b0;
            if (rx_dv_q) rx_index_q <= rx_index_q + CNT_W'(1);
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        tx_sr_q      <= CPHA ? i_TX_Word : {i_TX_Word[WORD_W-2:0], 1'b0};
                        if (!CPHA) mosi_q <= i_TX_Word[WORD_W-1];
                        words_left_q <= (i_TX_Count == '0) ? CNT_W'(1) : i_TX_Count;
                        rx_index_q   <= '0;
                        bit_cnt_q    <= '0;
                        cs_n_q       <= 1'b0;
                        tx_ready_q   <= 1'b0;
                        busy_q       <= 1'b1;
                        cs_cnt_q     <= '0;
                        state_q      <= StCsSetup;
                    end
                end
                StCsSetup: begin
                    if (cs_cnt_q == SetupLast) begin
                        cs_cnt_q <= '0;
                        state_q  <= StXfer;
                    end else begin
                        cs_cnt_q <= cs_cnt_q + CsCntW'(1);
                    end
                end
                StXfer: begin
                    if (sample_pulse) begin
                        rx_sr_q <= {rx_sr_q[WORD_W-3:0], i_SPI_MISO};
                        if (bit_cnt_q == BitLast) begin
                            rx_word_q <= {rx_sr_q, i_SPI_MISO};
                            rx_dv_q   <= 1'b1;
                            bit_cnt_q <= '0;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BitW'(1);
                        end
                    end
                    if (shift_pulse) begin
                        mosi_q  <= tx_sr_q[WORD_W-1];
                        tx_sr_q <= {tx_sr_q[WORD_W-2:0], 1'b0};
                    end
                    if (done_pulse) begin
                        words_left_q <= words_left_q - CNT_W'(1);
                        if (words_left_q == CNT_W'(1)) begin
                            cs_cnt_q <= '0;
                            state_q  <= StCsHold;
                        end else begin
                            tx_ready_q <= 1'b1;
                            state_q    <= StWaitWord;
                        end
                    end
                end
                StWaitWord: begin
                    if (accept) begin
                        tx_sr_q    <= CPHA ? i_TX_Word : {i_TX_Word[WORD_W-2:0], 1'b0};
                        if (!CPHA) mosi_q <= i_TX_Word[WORD_W-1];
                        tx_ready_q <= 1'b0;
                        state_q    <= StXfer;
                    end
                end
                StCsHold: begin
                    if (cs_cnt_q == HoldLast) begin
                        cs_n_q   <= 1'b1;
                        cs_cnt_q <= '0;
                        state_q  <= StCsIdle;
                    end else begin
                        cs_cnt_q <= cs_cnt_q + CsCntW'(1);
                    end
                end
                StCsIdle: begin
                    if (cs_cnt_q == IdleLast) begin
                        cs_cnt_q   <= '0;
                        busy_q     <= 1'b0;
                        tx_ready_q <= 1'b1;
                        state_q    <= StIdle;
                    end else begin
                        cs_cnt_q <= cs_cnt_q + CsCntW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign o_TX_Ready = tx_ready_q;
    assign o_RX_DV    = rx_dv_q;
    assign o_RX_Word  = rx_word_q;
    assign o_RX_Index = rx_index_q;
    assign o_Busy     = busy_q;
    assign o_SPI_MOSI = mosi_q;
    assign o_SPI_CS_n = cs_n_q;

endmodule

// File: tb/tb_spi_master_burst.sv
// Bench for spi_master_burst: three configurations, slave models and per-DUT scoreboards.
module tb_spi_master_burst;

    typedef struct packed {
        logic [3:0]  idx;
        logic [23:0] word;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Mode 0, 8-bit, MISO looped back from MOSI.
    logic [7:0] word0 = '0;
    logic [3:0] cnt0 = '0;
    logic       dv0 = 1'b0;
    logic       rdy0, rxdv0, busy0, sclk0, mosi0, csn0;
    logic [7:0] rxw0;
    logic [3:0] rxi0;
    spi_master_burst #(.WORD_W(8), .CPOL(1'b0), .CPHA(1'b0), .CLKS_PER_HALF_BIT(4)) u_m0 (
        .i_CLK(clk), .i_RST(rst), .i_TX_Word(word0), .i_TX_Count(cnt0), .i_TX_DV(dv0),
        .o_TX_Ready(rdy0), .o_RX_DV(rxdv0), .o_RX_Word(rxw0), .o_RX_Index(rxi0),
        .o_Busy(busy0), .o_SPI_Clk(sclk0), .i_SPI_MISO(mosi0), .o_SPI_MOSI(mosi0),
        .o_SPI_CS_n(csn0)
    );

    // Mode 3, 8-bit, ADS1292-like slave.
    logic [7:0] word3 = '0;
    logic [3:0] cnt3 = '0;
    logic       dv3 = 1'b0;
    logic       miso3 = 1'b0;
    logic       rdy3, rxdv3, busy3, sclk3, mosi3, csn3;
    logic [7:0] rxw3;
    logic [3:0] rxi3;
    spi_master_burst #(.WORD_W(8), .CPOL(1'b1), .CPHA(1'b1), .CLKS_PER_HALF_BIT(4)) u_m3 (
        .i_CLK(clk), .i_RST(rst), .i_TX_Word(word3), .i_TX_Count(cnt3), .i_TX_DV(dv3),
        .o_TX_Ready(rdy3), .o_RX_DV(rxdv3), .o_RX_Word(rxw3), .o_RX_Index(rxi3),
        .o_Busy(busy3), .o_SPI_Clk(sclk3), .i_SPI_MISO(miso3), .o_SPI_MOSI(mosi3),
        .o_SPI_CS_n(csn3)
    );

    // Mode 1, 24-bit, fast clock.
    logic [23:0] word1 = '0;
    logic [3:0]  cnt1 = '0;
    logic        dv1 = 1'b0;
    logic        miso1 = 1'b0;
    logic        rdy1, rxdv1, busy1, sclk1, mosi1, csn1;
    logic [23:0] rxw1;
    logic [3:0]  rxi1;
    spi_master_burst #(.WORD_W(24), .CPOL(1'b0), .CPHA(1'b1), .CLKS_PER_HALF_BIT(2)) u_m1 (
        .i_CLK(clk), .i_RST(rst), .i_TX_Word(word1), .i_TX_Count(cnt1), .i_TX_DV(dv1),
        .o_TX_Ready(rdy1), .o_RX_DV(rxdv1), .o_RX_Word(rxw1), .o_RX_Index(rxi1),
        .o_Busy(busy1), .o_SPI_Clk(sclk1), .i_SPI_MISO(miso1), .o_SPI_MOSI(mosi1),
        .o_SPI_CS_n(csn1)
    );

    exp_t exp0[$];
    exp_t exp3[$];
    exp_t exp1[$];
    exp_t e0, e3, e1;
    int rxn0 = 0, rxn3 = 0, rxn1 = 0;
    int edges0 = 0, cslow0 = 0, csidle0 = 0, cs3_rises = 0;
    logic [7:0]  mcap0 = '0;
    logic [23:0] mcap1 = '0;

    // Slave models.
    function automatic logic [7:0] ads_byte(input int i);
        case (i)
            0: return 8'hC0;
            1, 2: return 8'h00;
            default: return 8'(8'h12 + i - 3);
        endcase
    endfunction

    int ads_bit = 0;
    logic [7:0] ads_b;
    always @(negedge csn3) ads_bit = 0;
    always @(negedge sclk3) if (csn3 === 1'b0) begin
        if (ads_bit < 72) begin
            ads_b = ads_byte(ads_bit / 8);
            miso3 = ads_b[7 - (ads_bit % 8)];
        end
        ads_bit++;
    end

    int m1_bit = 0;
    logic [23:0] pat1 = 24'h5A5A5A;
    always @(negedge csn1) m1_bit = 0;
    always @(posedge sclk1) if (csn1 === 1'b0) begin
        if (m1_bit < 24) miso1 = pat1[23 - m1_bit];
        m1_bit++;
    end
    always @(negedge sclk1) if (csn1 === 1'b0) mcap1 = {mcap1[22:0], mosi1};

    // Pin-level observers.
    always @(sclk0) if (rst === 1'b0) edges0++;
    always @(posedge sclk0) if (csn0 === 1'b0) mcap0 = {mcap0[6:0], mosi0};
    always @(posedge csn3) if (rst === 1'b0) cs3_rises++;
    always @(negedge clk) begin
        if (csn0 === 1'b0) cslow0++;
        if (csn0 === 1'b1 && busy0 === 1'b1) csidle0++;
    end

    // Scoreboards.
    always @(negedge clk) if (rxdv0 === 1'b1) begin
        rxn0++; checks++;
        if (exp0.size() == 0) begin
            errors++; $display("FAIL m0_rx got word=%h idx=%0d want no word", rxw0, rxi0);
        end else begin
            e0 = exp0.pop_front();
            if (rxw0 !== e0.word[7:0] || rxi0 !== e0.idx) begin
                errors++;
                $display("FAIL m0_rx got word=%h idx=%0d want word=%h idx=%0d",
                         rxw0, rxi0, e0.word[7:0], e0.idx);
            end
        end
    end
    always @(negedge clk) if (rxdv3 === 1'b1) begin
        rxn3++; checks++;
        if (exp3.size() == 0) begin
            errors++; $display("FAIL m3_rx got word=%h idx=%0d want no word", rxw3, rxi3);
        end else begin
            e3 = exp3.pop_front();
            if (rxw3 !== e3.word[7:0] || rxi3 !== e3.idx) begin
                errors++;
                $display("FAIL m3_rx got word=%h idx=%0d want word=%h idx=%0d",
                         rxw3, rxi3, e3.word[7:0], e3.idx);
            end
        end
    end
    always @(negedge clk) if (rxdv1 === 1'b1) begin
        rxn1++; checks++;
        if (exp1.size() == 0) begin
            errors++; $display("FAIL m1_rx got word=%h idx=%0d want no word", rxw1, rxi1);
        end else begin
            e1 = exp1.pop_front();
            if (rxw1 !== e1.word || rxi1 !== e1.idx) begin
                errors++;
                $display("FAIL m1_rx got word=%h idx=%0d want word=%h idx=%0d",
                         rxw1, rxi1, e1.word, e1.idx);
            end
        end
    end

    // Drivers (called at a negedge; wait for ready, present one word for one cycle).
    task automatic m0_send(input logic [7:0] w, input logic [3:0] c, input logic [3:0] idx);
        int guard = 0;
        while (rdy0 !== 1'b1 && guard < 2000) begin @(negedge clk); guard++; end
        word0 = w; cnt0 = c; dv0 = 1'b1;
        exp0.push_back({idx, 16'h0, w});
        @(negedge clk);
        dv0 = 1'b0;
    endtask

    task automatic m3_send(input logic [7:0] w, input logic [3:0] c, input logic [3:0] idx);
        int guard = 0;
        while (rdy3 !== 1'b1 && guard < 2000) begin @(negedge clk); guard++; end
        word3 = w; cnt3 = c; dv3 = 1'b1;
        exp3.push_back({idx, 16'h0, ads_byte(int'(idx))});
        @(negedge clk);
        dv3 = 1'b0;
    endtask

    task automatic wait_idle(input int which);
        int guard = 0;
        @(negedge clk);
        while (guard < 5000 && ((which == 0 && (busy0 !== 1'b0 || rdy0 !== 1'b1)) ||
                                (which == 3 && (busy3 !== 1'b0 || rdy3 !== 1'b1)) ||
                                (which == 1 && (busy1 !== 1'b0 || rdy1 !== 1'b1)))) begin
            @(negedge clk); guard++;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks += 9;
        if (rdy0 !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", rdy0); end
        if (rxdv0 !== 1'b0) begin errors++; $display("FAIL reset_rxdv got %b want 0", rxdv0); end
        if (rxw0 !== 8'h00) begin errors++; $display("FAIL reset_rxword got %h want 00", rxw0); end
        if (rxi0 !== 4'h0) begin errors++; $display("FAIL reset_rxidx got %0d want 0", rxi0); end
        if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy0); end
        if (sclk0 !== 1'b0) begin errors++; $display("FAIL reset_sclk0 got %b want 0", sclk0); end
        if (mosi0 !== 1'b0) begin errors++; $display("FAIL reset_mosi got %b want 0", mosi0); end
        if (csn0 !== 1'b1) begin errors++; $display("FAIL reset_csn got %b want 1", csn0); end
        if (sclk3 !== 1'b1) begin errors++; $display("FAIL reset_sclk3 got %b want 1", sclk3); end
    endtask

    task automatic test_mode0_single();
        int base = rxn0;
        edges0 = 0; cslow0 = 0; csidle0 = 0; mcap0 = '0;
        m0_send(8'hA5, 4'd1, 4'd0);
        wait_idle(0);
        checks += 5;
        if (rxn0 - base != 1) begin errors++; $display("FAIL m0_rx_count got %0d want 1", rxn0 - base); end
        if (edges0 != 16) begin errors++; $display("FAIL m0_edges got %0d want 16", edges0); end
        if (cslow0 != 68) begin errors++; $display("FAIL m0_cs_low got %0d want 68", cslow0); end
        if (csidle0 < 2) begin errors++; $display("FAIL m0_cs_idle got %0d want >=2", csidle0); end
        if (mcap0 !== 8'hA5) begin errors++; $display("FAIL m0_mosi got %h want a5", mcap0); end
    endtask

    task automatic test_mode3_burst();
        int base = rxn3;
        cs3_rises = 0;
        for (int i = 0; i < 9; i++) m3_send(8'(8'h20 + i), 4'd9, 4'(i));
        wait_idle(3);
        checks += 3;
        if (rxn3 - base != 9) begin errors++; $display("FAIL m3_rx_count got %0d want 9", rxn3 - base); end
        if (cs3_rises != 1) begin errors++; $display("FAIL m3_cs_rises got %0d want 1", cs3_rises); end
        if (exp3.size() != 0) begin errors++; $display("FAIL m3_pending got %0d want 0", exp3.size()); end
    endtask

    task automatic test_stall();
        int base = rxn0;
        int bad = 0;
        int guard = 0;
        m0_send(8'h11, 4'd3, 4'd0);
        while (rdy0 !== 1'b1 && guard < 1000) begin @(negedge clk); guard++; end
        for (int i = 0; i < 50; i++) begin
            if (sclk0 !== 1'b0 || csn0 !== 1'b0 || rdy0 !== 1'b1) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL stall_hold got %0d bad cycles want 0", bad); end
        m0_send(8'h22, 4'd0, 4'd1);
        m0_send(8'h33, 4'd0, 4'd2);
        wait_idle(0);
        checks += 2;
        if (rxn0 - base != 3) begin errors++; $display("FAIL stall_rx_count got %0d want 3", rxn0 - base); end
        if (mcap0 !== 8'h33) begin errors++; $display("FAIL stall_mosi got %h want 33", mcap0); end
    endtask

    task automatic test_ignore_dv();
        int base = rxn0;
        mcap0 = '0;
        m0_send(8'h3C, 4'd0, 4'd0);
        repeat (20) @(negedge clk);
        checks++;
        if (rdy0 !== 1'b0) begin errors++; $display("FAIL xfer_ready got %b want 0", rdy0); end
        word0 = 8'hFF; cnt0 = 4'd5; dv0 = 1'b1;
        @(negedge clk);
        dv0 = 1'b0;
        wait_idle(0);
        repeat (20) @(negedge clk);
        checks += 4;
        if (rxn0 - base != 1) begin errors++; $display("FAIL count0_rx_count got %0d want 1", rxn0 - base); end
        if (mcap0 !== 8'h3C) begin errors++; $display("FAIL ignore_mosi got %h want 3c", mcap0); end
        if (rxi0 !== 4'd1) begin errors++; $display("FAIL count0_index got %0d want 1", rxi0); end
        if (busy0 !== 1'b0) begin errors++; $display("FAIL ignore_busy got %b want 0", busy0); end
    endtask

    task automatic test_reset_midburst();
        int base = rxn0;
        int guard = 0;
        m0_send(8'hC3, 4'd4, 4'd0);
        m0_send(8'h96, 4'd0, 4'd1);
        void'(exp0.pop_back());  // word 1 is aborted and must never complete
        edges0 = 0;
        while (edges0 < 7 && guard < 500) begin @(negedge clk); guard++; end
        rst = 1'b1;
        #1;
        checks += 3;
        if (csn0 !== 1'b1) begin errors++; $display("FAIL abort_csn got %b want 1", csn0); end
        if (sclk0 !== 1'b0) begin errors++; $display("FAIL abort_sclk got %b want 0", sclk0); end
        if (rdy0 !== 1'b1) begin errors++; $display("FAIL abort_ready got %b want 1", rdy0); end
        @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        checks += 2;
        if (rxn0 - base != 1) begin errors++; $display("FAIL abort_rx_count got %0d want 1", rxn0 - base); end
        if (exp0.size() != 0) begin errors++; $display("FAIL abort_pending got %0d want 0", exp0.size()); end
        m0_send(8'h5E, 4'd1, 4'd0);
        wait_idle(0);
        checks += 2;
        if (rxn0 - base != 2) begin errors++; $display("FAIL post_abort_count got %0d want 2", rxn0 - base); end
        if (mcap0 !== 8'h5E) begin errors++; $display("FAIL post_abort_mosi got %h want 5e", mcap0); end
    endtask

    task automatic test_mode1_w24();
        int base = rxn1;
        int guard = 0;
        mcap1 = '0;
        while (rdy1 !== 1'b1 && guard < 1000) begin @(negedge clk); guard++; end
        word1 = 24'h800001; cnt1 = 4'd1; dv1 = 1'b1;
        exp1.push_back({4'd0, 24'h5A5A5A});
        @(negedge clk);
        dv1 = 1'b0;
        wait_idle(1);
        checks += 3;
        if (rxn1 - base != 1) begin errors++; $display("FAIL m1_rx_count got %0d want 1", rxn1 - base); end
        if (mcap1 !== 24'h800001) begin errors++; $display("FAIL m1_mosi got %h want 800001", mcap1); end
        if (rxw1 !== 24'h5A5A5A) begin errors++; $display("FAIL m1_rxword got %h want 5a5a5a", rxw1); end
    endtask

    initial begin
        test_reset();
        test_mode0_single();
        test_mode3_burst();
        test_stall();
        test_ignore_dv();
        test_reset_midburst();
        test_mode1_w24();
        repeat (5) @(negedge clk);
        checks++;
        if (exp0.size() + exp3.size() + exp1.size() != 0) begin
            errors++;
            $display("FAIL final_pending got %0d want 0", exp0.size() + exp3.size() + exp1.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
